// File: rtl/al_mode_controller_pkg.sv
// Shared definitions for the alarm-clock mode/set controller: mode encodings,
// reset alarm time and BCD digit limits.
package al_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_t;

  localparam logic [15:0] ALARM_RESET_BCD = 16'h0600;

  localparam logic [3:0] MIN_LS_MAX  = 4'd9;
  localparam logic [3:0] MIN_MS_MAX  = 4'd5;
  localparam logic [3:0] HOUR_LS_MAX = 4'd9;
  // Two BCD digits, i.e. 23 o'clock.
  localparam logic [7:0] HOUR_MAX    = 8'h23;

endpackage

// File: rtl/bcd_hhmm_step.sv
// Combinational one-step increment of a packed BCD HH:MM value.
// wrap flags the hour rolling over from 23 to 00.
module bcd_hhmm_step
  import al_pkg::*;
(
  input  logic [15:0] cur,
  input  logic        inc_min,
  input  logic        inc_hour,
  input  logic        carry_en,
  output logic [15:0] nxt,
  output logic        wrap
);

  logic [3:0] hm, hl, mm, ml;
  logic       min_carry;
  logic       hour_step;

  always_comb begin
    {hm, hl, mm, ml} = cur;
    min_carry = 1'b0;
    wrap      = 1'b0;

    if (inc_min) begin
      if (ml == MIN_LS_MAX) begin
        ml = '0;
        if (mm == MIN_MS_MAX) begin
          mm        = '0;
          min_carry = 1'b1;
        end else begin
          mm = mm + 4'd1;
        end
      end else begin
        ml = ml + 4'd1;
      end
    end

    // Manual minute edits leave the hour alone; only clock advance carries.
    hour_step = inc_hour | (min_carry & carry_en);

    if (hour_step) begin
      if ({hm, hl} == HOUR_MAX) begin
        hm   = '0;
        hl   = '0;
        wrap = 1'b1;
      end else if (hl == HOUR_LS_MAX) begin
        hl = '0;
        hm = hm + 4'd1;
      end else begin
        hl = hl + 4'd1;
      end
    end

    nxt = {hm, hl, mm, ml};
  end

endmodule

// File: rtl/al_mode_controller.sv
// Alarm-clock mode/set controller: owns time and alarm BCD registers, button
// editing, alarm ringing and the blinking 7-segment digit selection.
module al_mode_controller
  import al_pkg::*;
#(
  parameter int unsigned BLINK_DIV    = 12_500_000,
  parameter int unsigned RING_MINUTES = 1
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        one_minute,
  input  logic        btn_mode,
  input  logic        btn_hour,
  input  logic        btn_min,
  input  logic        btn_stop,
  input  logic        alarm_en,
  output logic [15:0] time_bcd,
  output logic [15:0] alarm_bcd,
  output logic [15:0] word_out,
  output logic [3:0]  display_mask,
  output logic [1:0]  mode,
  output logic        ringing
);

  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [5:0] raw_in, sync1, sync2;
  logic [4:0] edge_q, rise;
  logic       tick, mode_p, hour_p, min_p, stop_p, alarm_en_s;
  logic       hour_e, min_e, tick_upd, blink_restart;

  mode_t      mode_q, mode_nxt;
  logic [3:0] ring_cnt;
  logic       match_pend;
  logic [BLINK_W-1:0] blink_cnt;
  logic       blink_on;

  logic [15:0] time_nxt, alarm_nxt;
  logic        t_inc_min, t_inc_hour, t_carry, a_inc_min, a_inc_hour;
  logic        time_wrap, alarm_wrap, unused_wraps;

  assign raw_in = {alarm_en, btn_stop, btn_min, btn_hour, btn_mode, one_minute};
  assign rise   = sync2[4:0] & ~edge_q;
  assign {stop_p, min_p, hour_p, mode_p, tick} = rise;
  assign alarm_en_s = sync2[5];

  // A mode press wins the cycle; hour beats minute.
  assign hour_e = hour_p & ~mode_p;
  assign min_e  = min_p & ~mode_p & ~hour_p;

  assign t_inc_min  = (mode_q == MODE_SET_TIME) ? min_e : tick;
  assign t_inc_hour = (mode_q == MODE_SET_TIME) & hour_e;
  assign t_carry    = (mode_q != MODE_SET_TIME);
  assign a_inc_min  = (mode_q == MODE_SET_ALARM) & min_e;
  assign a_inc_hour = (mode_q == MODE_SET_ALARM) & hour_e;
  assign tick_upd   = tick & (mode_q != MODE_SET_TIME);

  assign blink_restart = mode_p | (mode_q == MODE_RUN) | hour_e | min_e;

  assign unused_wraps = time_wrap | alarm_wrap;
  assign mode         = mode_q;

  bcd_hhmm_step u_time_step (
    .cur      (time_bcd),
    .inc_min  (t_inc_min),
    .inc_hour (t_inc_hour),
    .carry_en (t_carry),
    .nxt      (time_nxt),
    .wrap     (time_wrap)
  );

  bcd_hhmm_step u_alarm_step (
    .cur      (alarm_bcd),
    .inc_min  (a_inc_min),
    .inc_hour (a_inc_hour),
    .carry_en (1'b0),
    .nxt      (alarm_nxt),
    .wrap     (alarm_wrap)
  );

  always_comb begin
    mode_nxt = mode_q;
    if (mode_p) begin
      case (mode_q)
        MODE_RUN:       mode_nxt = MODE_SET_TIME;
        MODE_SET_TIME:  mode_nxt = MODE_SET_ALARM;
        default:        mode_nxt = MODE_RUN;
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      sync1        <= '0;
      sync2        <= '0;
      edge_q       <= '0;
      mode_q       <= MODE_RUN;
      time_bcd     <= '0;
      alarm_bcd    <= ALARM_RESET_BCD;
      match_pend   <= 1'b0;
      ringing      <= 1'b0;
      ring_cnt     <= '0;
      blink_cnt    <= '0;
      blink_on     <= 1'b1;
      word_out     <= '0;
      display_mask <= '1;
    end else begin
      sync1     <= raw_in;
      sync2     <= sync1;
      edge_q    <= sync2[4:0];
      mode_q    <= mode_nxt;
      time_bcd  <= time_nxt;
      alarm_bcd <= alarm_nxt;

      // Match is judged on the freshly advanced time; ringing follows one edge later.
      match_pend <= tick_upd & alarm_en_s & (time_nxt == alarm_bcd);

      if (match_pend && alarm_en_s) begin
        ringing  <= 1'b1;
        ring_cnt <= 4'(RING_MINUTES);
      end else if (ringing) begin
        if (stop_p || !alarm_en_s) begin
          ringing  <= 1'b0;
          ring_cnt <= '0;
        end else if (tick) begin
          if (ring_cnt <= 4'd1) begin
            ringing  <= 1'b0;
            ring_cnt <= '0;
          end else begin
            ring_cnt <= ring_cnt - 4'd1;
          end
        end
      end

      if (blink_restart) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      word_out     <= (mode_q == MODE_SET_ALARM) ? alarm_bcd : time_bcd;
      display_mask <= (mode_q == MODE_RUN) ? 4'b1111 : {4{blink_on}};
    end
  end

endmodule

// File: tb/tb_al_mode_controller.sv
// Self-checking bench for al_mode_controller: directed vector table, corner
// sequences, then random button/tick traffic against a minutes-of-day model.
module tb_al_mode_controller;

  localparam int BLINK = 8;
  localparam int RING  = 1;

  localparam int ACT_TICK = 0;
  localparam int ACT_MODE = 1;
  localparam int ACT_HOUR = 2;
  localparam int ACT_MIN  = 3;
  localparam int ACT_STOP = 4;

  logic        MCLK = 1'b0;
  logic        reset = 1'b1;
  logic        one_minute = 1'b0;
  logic        btn_mode = 1'b0, btn_hour = 1'b0, btn_min = 1'b0, btn_stop = 1'b0;
  logic        alarm_en = 1'b0;
  logic [15:0] time_bcd, alarm_bcd, word_out;
  logic [3:0]  display_mask;
  logic [1:0]  mode;
  logic        ringing;

  al_mode_controller #(.BLINK_DIV(BLINK), .RING_MINUTES(RING)) dut (
    .MCLK         (MCLK),
    .reset        (reset),
    .one_minute   (one_minute),
    .btn_mode     (btn_mode),
    .btn_hour     (btn_hour),
    .btn_min      (btn_min),
    .btn_stop     (btn_stop),
    .alarm_en     (alarm_en),
    .time_bcd     (time_bcd),
    .alarm_bcd    (alarm_bcd),
    .word_out     (word_out),
    .display_mask (display_mask),
    .mode         (mode),
    .ringing      (ringing)
  );

  always #5 MCLK = ~MCLK;

  int errors = 0;
  int checks = 0;

  // Reference model: times as minutes since midnight.
  int m_time, m_alarm, m_mode, m_cnt;
  bit m_ring, m_en;

  typedef struct {
    int          act;
    int          reps;
    logic [15:0] t;
    logic [15:0] a;
    logic [1:0]  md;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [15:0] to_bcd(input int mins);
    int h, m;
    h = mins / 60;
    m = mins % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic int bump_hour(input int x);
    return ((x / 60 + 1) % 24) * 60 + x % 60;
  endfunction

  function automatic int bump_min(input int x);
    return (x / 60) * 60 + (x % 60 + 1) % 60;
  endfunction

  task automatic model_reset();
    m_time = 0; m_alarm = 360; m_mode = 0; m_ring = 0; m_cnt = 0;
  endtask

  task automatic model_apply(input int act);
    case (act)
      ACT_TICK: begin
        if (m_mode != 1) m_time = (m_time + 1) % 1440;
        if (m_ring) begin
          m_cnt = m_cnt - 1;
          if (m_cnt <= 0) m_ring = 0;
        end
        if (m_mode != 1 && m_en && m_time == m_alarm) begin
          m_ring = 1;
          m_cnt  = RING;
        end
      end
      ACT_MODE: m_mode = (m_mode + 1) % 3;
      ACT_HOUR: begin
        if (m_mode == 1) m_time = bump_hour(m_time);
        else if (m_mode == 2) m_alarm = bump_hour(m_alarm);
      end
      ACT_MIN: begin
        if (m_mode == 1) m_time = bump_min(m_time);
        else if (m_mode == 2) m_alarm = bump_min(m_alarm);
      end
      default: m_ring = 0;
    endcase
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] et, ea;
    et = to_bcd(m_time);
    ea = to_bcd(m_alarm);
    chk({tag, " time"}, time_bcd, et);
    chk({tag, " alarm"}, alarm_bcd, ea);
    chk({tag, " mode"}, {14'b0, mode}, 16'(m_mode));
    chk({tag, " ringing"}, {15'b0, ringing}, {15'b0, m_ring});
    chk({tag, " word_out"}, word_out, (m_mode == 2) ? ea : et);
    if (m_mode == 0) chk({tag, " mask"}, {12'b0, display_mask}, 16'h000f);
  endtask

  task automatic drive(input int act, input logic v);
    case (act)
      ACT_TICK: one_minute = v;
      ACT_MODE: btn_mode   = v;
      ACT_HOUR: btn_hour   = v;
      ACT_MIN:  btn_min    = v;
      default:  btn_stop   = v;
    endcase
  endtask

  // Held for several cycles to confirm no auto-repeat; returns 4 edges after the update edge.
  task automatic pulse(input int act);
    drive(act, 1'b1);
    repeat (4) @(negedge MCLK);
    drive(act, 1'b0);
    repeat (3) @(negedge MCLK);
    model_apply(act);
  endtask

  task automatic pulse2(input int a, input int b);
    drive(a, 1'b1);
    drive(b, 1'b1);
    repeat (4) @(negedge MCLK);
    drive(a, 1'b0);
    drive(b, 1'b0);
    repeat (3) @(negedge MCLK);
  endtask

  task automatic set_en(input logic v);
    alarm_en = v;
    repeat (5) @(negedge MCLK);
    m_en = v;
    if (!v) m_ring = 0;
  endtask

  // Program alarm to one minute past current time (must be in SET_ALARM).
  task automatic alarm_to_next();
    int target, g;
    target = (m_time + 1) % 1440;
    g = 0;
    while (m_alarm / 60 != target / 60 && g < 30) begin pulse(ACT_HOUR); g++; end
    while (m_alarm % 60 != target % 60 && g < 100) begin pulse(ACT_MIN); g++; end
    chk("alarm_program", alarm_bcd, to_bcd(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{ACT_TICK, 1,  16'h0001, 16'h0600, 2'd0};
    tbl[1]  = '{ACT_TICK, 9,  16'h0010, 16'h0600, 2'd0};
    tbl[2]  = '{ACT_TICK, 50, 16'h0100, 16'h0600, 2'd0};
    tbl[3]  = '{ACT_MODE, 1,  16'h0100, 16'h0600, 2'd1};
    tbl[4]  = '{ACT_HOUR, 22, 16'h2300, 16'h0600, 2'd1};
    tbl[5]  = '{ACT_MIN,  59, 16'h2359, 16'h0600, 2'd1};
    tbl[6]  = '{ACT_TICK, 3,  16'h2359, 16'h0600, 2'd1};
    tbl[7]  = '{ACT_MODE, 2,  16'h2359, 16'h0600, 2'd0};
    tbl[8]  = '{ACT_TICK, 1,  16'h0000, 16'h0600, 2'd0};
    tbl[9]  = '{ACT_MODE, 2,  16'h0000, 16'h0600, 2'd2};
    tbl[10] = '{ACT_HOUR, 18, 16'h0000, 16'h0000, 2'd2};
    tbl[11] = '{ACT_MIN,  2,  16'h0000, 16'h0002, 2'd2};
    tbl[12] = '{ACT_TICK, 1,  16'h0001, 16'h0002, 2'd2};
    tbl[13] = '{ACT_MODE, 1,  16'h0001, 16'h0002, 2'd0};

    model_reset();
    m_en = 0;
    repeat (3) @(negedge MCLK);
    chk("reset time", time_bcd, 16'h0000);
    chk("reset alarm", alarm_bcd, 16'h0600);
    chk("reset word_out", word_out, 16'h0000);
    chk("reset mask", {12'b0, display_mask}, 16'h000f);
    chk("reset mode", {14'b0, mode}, 16'h0000);
    chk("reset ringing", {15'b0, ringing}, 16'h0000);
    reset = 1'b0;
    @(negedge MCLK);

    for (int i = 0; i < 14; i++) begin
      repeat (tbl[i].reps) pulse(tbl[i].act);
      chk($sformatf("vec%0d time", i), time_bcd, tbl[i].t);
      chk($sformatf("vec%0d alarm", i), alarm_bcd, tbl[i].a);
      chk($sformatf("vec%0d mode", i), {14'b0, mode}, {14'b0, tbl[i].md});
      chk($sformatf("vec%0d word_out", i), word_out, (tbl[i].md == 2'd2) ? tbl[i].a : tbl[i].t);
    end

    // Ring latency: time updates on edge 3, ringing on edge 4.
    set_en(1'b1);
    one_minute = 1'b1;
    repeat (3) @(negedge MCLK);
    chk("ring_edge3 time", time_bcd, 16'h0002);
    chk("ring_edge3 ringing", {15'b0, ringing}, 16'h0000);
    @(negedge MCLK);
    chk("ring_edge4 ringing", {15'b0, ringing}, 16'h0001);
    one_minute = 1'b0;
    repeat (3) @(negedge MCLK);
    model_apply(ACT_TICK);
    check_all("ring");

    btn_stop = 1'b1;
    repeat (3) @(negedge MCLK);
    chk("stop clears", {15'b0, ringing}, 16'h0000);
    btn_stop = 1'b0;
    repeat (4) @(negedge MCLK);
    model_apply(ACT_STOP);
    check_all("after_stop");

    pulse(ACT_MODE); pulse(ACT_MODE); pulse(ACT_MIN); pulse(ACT_MODE);
    pulse(ACT_TICK);
    chk("retrigger ringing", {15'b0, ringing}, 16'h0001);
    check_all("retrigger");
    pulse(ACT_TICK);
    chk("self_clear ringing", {15'b0, ringing}, 16'h0000);
    check_all("self_clear");

    pulse(ACT_MODE); pulse(ACT_MODE); pulse(ACT_MIN); pulse(ACT_MIN); pulse(ACT_MODE);
    pulse(ACT_TICK);
    chk("en_ring ringing", {15'b0, ringing}, 16'h0001);
    alarm_en = 1'b0;
    repeat (3) @(negedge MCLK);
    chk("en_off clears", {15'b0, ringing}, 16'h0000);
    repeat (2) @(negedge MCLK);
    m_en = 0; m_ring = 0;
    check_all("en_off");

    pulse(ACT_MODE);
    pulse2(ACT_MODE, ACT_HOUR); model_apply(ACT_MODE);
    check_all("mode_beats_hour");
    pulse2(ACT_MODE, ACT_MIN); model_apply(ACT_MODE);
    check_all("mode_beats_min");
    pulse(ACT_MODE);
    pulse2(ACT_HOUR, ACT_MIN); model_apply(ACT_HOUR);
    check_all("hour_beats_min");
    pulse(ACT_MODE);
    pulse2(ACT_TICK, ACT_HOUR); model_apply(ACT_TICK); model_apply(ACT_HOUR);
    check_all("tick_and_edit");

    // Blink in SET_ALARM: restart on press, then fixed BLINK-cycle half periods.
    pulse(ACT_HOUR);
    chk("blink restart on", {12'b0, display_mask}, 16'h000f);
    begin
      logic [3:0] prev;
      int run, trans, bad;
      bit first;
      prev = display_mask; run = 0; trans = 0; bad = 0; first = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge MCLK);
        run++;
        if (display_mask != prev) begin
          if (!first && run != BLINK) bad++;
          if (!((display_mask == 4'hf && prev == 4'h0) || (display_mask == 4'h0 && prev == 4'hf))) bad++;
          first = 0; trans++; run = 0; prev = display_mask;
        end
      end
      chk("blink period errors", 16'(bad), 16'h0000);
      chk("blink toggled", {15'b0, trans >= 4}, 16'h0001);
    end
    begin
      int g;
      g = 0;
      while (display_mask != 4'h0 && g < 3 * BLINK) begin @(negedge MCLK); g++; end
      chk("blink reached off", {12'b0, display_mask}, 16'h0000);
      pulse(ACT_MIN);
      chk("blink restart mid-off", {12'b0, display_mask}, 16'h000f);
    end
    check_all("after_blink");

    // Ringing in SET_ALARM, then reset mid-blink.
    set_en(1'b1);
    alarm_to_next();
    pulse(ACT_TICK);
    chk("setalarm ringing", {15'b0, ringing}, 16'h0001);
    check_all("setalarm_ring");
    repeat (3) @(negedge MCLK);
    reset = 1'b1;
    @(negedge MCLK);
    chk("midreset time", time_bcd, 16'h0000);
    chk("midreset alarm", alarm_bcd, 16'h0600);
    chk("midreset word_out", word_out, 16'h0000);
    chk("midreset mask", {12'b0, display_mask}, 16'h000f);
    chk("midreset mode", {14'b0, mode}, 16'h0000);
    chk("midreset ringing", {15'b0, ringing}, 16'h0000);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge MCLK);

    for (int i = 0; i < 150; i++) begin
      int r;
      r = int'($urandom_range(0, 7));
      case (r)
        0, 1, 2: pulse(ACT_TICK);
        3:       pulse(ACT_MODE);
        4:       pulse(ACT_HOUR);
        5:       pulse(ACT_MIN);
        6:       pulse(ACT_STOP);
        default: begin
          if (m_mode == 2 && $urandom_range(0, 1) == 1) alarm_to_next();
          else set_en(~alarm_en);
        end
      endcase
      check_all($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
